irq_ctrl: RTL
=============

// Module: irq_ctrl
// PURPOSE
//  Interrupt controller for the jacaranda-8 CPU. Latches edge events from up to
//  N_SRC peripheral sources (UART rx, GPIO, timer, ...), masks and prioritises
//  them, and drives the CPU's single int_req/int_vec pair. Memory-mapped beside
//  UART/GPIO in the top-level 8-bit MMIO space; replaces the fixed int_vec reg.
// PARAMETERS
//  N_SRC        4        number of interrupt sources (1..8)
//  SYNC_STAGES  2        synchroniser depth on src_irq (0 = sources already synchronous)
//  VEC_SHIFT    2        vector = vbase + (id << VEC_SHIFT)
//  ADDR_VBASE   8'd250   vector base register (RW)
//  ADDR_MASK    8'd248   enable mask register (RW, 1 = enabled)
//  ADDR_PEND    8'd247   pending register (R; W1C)
//  ADDR_STAT    8'd246   status (R): {state[1:0], 3'b0, active_id[2:0]}
// PORTS
//  clock        in   1      system clock
//  reset        in   1      asynchronous, active-high
//  src_irq      in   N_SRC  raw source lines, rising edge = event
//  access_addr  in   8      CPU data address (rs_data)
//  w_data       in   8      CPU write data (rd_data)
//  w_en         in   1      CPU store strobe (mem_w_en)
//  r_data       out  8      register read data, combinational from access_addr
//  r_hit        out  1      access_addr matches one of the four registers
//  int_ack      in   1      1-cycle pulse: CPU has taken the vector
//  int_done     in   1      1-cycle pulse: CPU executed return-from-interrupt
//  int_req      out  1      interrupt request to CPU
//  int_vec      out  8      handler address, valid while int_req or in SERVICE
// BEHAVIOUR
//  Reset: mask=0, pend=0, vbase=0, sync/edge flops=0, state=IDLE, int_req=0,
//   int_vec=0, active_id=0; r_data/r_hit follow address only.
//  Edge detect: event when synced line is 1 and its previous sample was 0; sets
//   pend[i] next edge. Rising edge to pend set = SYNC_STAGES+1 clocks.
//  Masked sources still latch pend; mask gates only request generation.
//  W1C: write to ADDR_PEND clears bits where w_data=1; a new event on the same
//   bit in the same cycle wins (bit stays set). Bits >= N_SRC read 0.
//  Priority: lowest index of (pend & mask) wins; fixed, not rotating.
//  FSM (state code in STAT):
//   IDLE(0): if (pend&mask)!=0 -> REQ; latch active_id,
//     int_vec = vbase + (id<<VEC_SHIFT) (8-bit wrap). int_req=1 next cycle.
//   REQ(1): int_req=1; id/vec frozen even if mask or pend change meanwhile.
//     int_ack -> SERVICE, clear pend[active_id] (ack beats W1C/new event on that
//     bit only for this cycle's clear; a simultaneous new event re-sets it).
//   SERVICE(2): int_req=0, no nesting; int_done -> IDLE. Pending re-evaluated
//     in IDLE, so back-to-back interrupts need >=1 IDLE cycle.
//  int_ack outside REQ and int_done outside SERVICE are ignored.
//  vbase write during REQ/SERVICE does not alter the latched int_vec.
//  Reset asserted mid-operation: immediate return to reset values, events lost.
//  Register writes take effect on the clock edge of the w_en cycle; reads are
//   combinational, same-cycle.
// STRUCTURE
//  Shared header irq_defs.vh: ADDR_* defaults, state encodings
//   (IRQ_IDLE=2'd0, IRQ_REQ=2'd1, IRQ_SVC=2'd2).
//  One sub-module: irq_prio_enc (N_SRC-bit vector -> valid + 3-bit id).
//  Synchroniser, edge detect, regs and FSM stay in irq_ctrl.
// TESTING
//  1 vbase=0x40, mask=0x01, pulse src_irq[0] -> int_req after SYNC+2 clocks,
//    int_vec=0x40; int_ack -> pend[0]=0, STAT=0x80; int_done -> STAT=0x00.
//  2 mask=0x0F, src[3] and src[1] same cycle -> id=1, vec=vbase+4; after done,
//    one IDLE cycle then id=3, vec=vbase+12.
//  3 mask=0, pulse src[2] -> no int_req, PEND reads 0x04; write mask=0x04 ->
//    int_req next+1 cycle; W1C 0x04 in same cycle as new src[2] edge -> stays set.
//  4 vbase=0xFC, id=2 -> int_vec=0x04 (wrap); change vbase in SERVICE -> vec held.
//  5 assert reset during REQ -> int_req=0, all regs 0 same cycle (async);
//    spurious int_ack/int_done in IDLE -> no state change.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map defaults, FSM state codes
// and the vector arithmetic used when a source is accepted.
package irq_ctrl_pkg;

    localparam logic [7:0] ADDR_VBASE_DEF = 8'd250;
    localparam logic [7:0] ADDR_MASK_DEF  = 8'd248;
    localparam logic [7:0] ADDR_PEND_DEF  = 8'd247;
    localparam logic [7:0] ADDR_STAT_DEF  = 8'd246;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_SVC  = 2'd2
    } irq_state_t;

    // Handler address wraps inside the 8-bit space.
    function automatic logic [7:0] irq_vec_calc(input logic [7:0] vbase,
                                                input logic [2:0] id,
                                                input int         shift);
        logic [7:0] off;
        off = {5'b00000, id} << shift;
        return vbase + off;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder, lowest set index wins; purely combinational, no backpressure.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic         vld,
    output logic [2:0]   id
);

    always_comb begin
        vld = |req;
        id  = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) id = 3'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-latching, masked, fixed-priority interrupt controller with an MMIO register file.
// Source edge to int_req in SYNC_STAGES+2 clocks; one request in flight, held until int_ack/int_done.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int         N_SRC       = 4,
    parameter int         SYNC_STAGES = 2,
    parameter int         VEC_SHIFT   = 2,
    parameter logic [7:0] ADDR_VBASE  = ADDR_VBASE_DEF,
    parameter logic [7:0] ADDR_MASK   = ADDR_MASK_DEF,
    parameter logic [7:0] ADDR_PEND   = ADDR_PEND_DEF,
    parameter logic [7:0] ADDR_STAT   = ADDR_STAT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq,
    input  logic [7:0]       access_addr,
    input  logic [7:0]       w_data,
    input  logic             w_en,
    output logic [7:0]       r_data,
    output logic             r_hit,
    input  logic             int_ack,
    input  logic             int_done,
    output logic             int_req,
    output logic [7:0]       int_vec
);

    logic [N_SRC-1:0] synced;
    logic [N_SRC-1:0] sync_prev;
    logic [N_SRC-1:0] src_edge;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] req_vec;
    logic [7:0]       vbase;
    logic [7:0]       pend_ext;
    logic [7:0]       mask_ext;
    logic [2:0]       active_id;
    logic             win_vld;
    logic [2:0]       win_id;
    irq_state_t       state;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign synced = src_irq;
        end else begin : g_sync
            logic [N_SRC-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
                end else begin
                    sync_q[0] <= src_irq;
                    for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
                end
            end
            assign synced = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign src_edge = synced & ~sync_prev;
    assign w1c      = (w_en && access_addr == ADDR_PEND) ? w_data[N_SRC-1:0] : '0;
    assign req_vec  = pend & mask;

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ack_clr[i] = (state == IRQ_REQ) && int_ack && (active_id == 3'(i));
        end
    end

    irq_prio_enc #(.N(N_SRC)) u_prio (
        .req (req_vec),
        .vld (win_vld),
        .id  (win_id)
    );

    // A fresh edge is OR-ed in last so it survives both W1C and the ack clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_prev <= '0;
            pend      <= '0;
            mask      <= '0;
            vbase     <= 8'h00;
        end else begin
            sync_prev <= synced;
            pend      <= (pend & ~w1c & ~ack_clr) | src_edge;
            if (w_en && access_addr == ADDR_MASK)  mask  <= w_data[N_SRC-1:0];
            if (w_en && access_addr == ADDR_VBASE) vbase <= w_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IRQ_IDLE;
            int_req   <= 1'b0;
            int_vec   <= 8'h00;
            active_id <= 3'd0;
        end else begin
            case (state)
                IRQ_IDLE: begin
                    if (win_vld) begin
                        state     <= IRQ_REQ;
                        int_req   <= 1'b1;
                        active_id <= win_id;
                        int_vec   <= irq_vec_calc(vbase, win_id, VEC_SHIFT);
                    end
                end
                IRQ_REQ: begin
                    if (int_ack) begin
                        state   <= IRQ_SVC;
                        int_req <= 1'b0;
                    end
                end
                IRQ_SVC: begin
                    if (int_done) state <= IRQ_IDLE;
                end
                default: begin
                    state   <= IRQ_IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pend_ext             = 8'h00;
        pend_ext[N_SRC-1:0]  = pend;
        mask_ext             = 8'h00;
        mask_ext[N_SRC-1:0]  = mask;
        r_data               = 8'h00;
        r_hit                = 1'b0;
        case (access_addr)
            ADDR_VBASE: begin r_data = vbase;    r_hit = 1'b1; end
            ADDR_MASK:  begin r_data = mask_ext; r_hit = 1'b1; end
            ADDR_PEND:  begin r_data = pend_ext; r_hit = 1'b1; end
            ADDR_STAT:  begin r_data = {state, 3'b000, active_id}; r_hit = 1'b1; end
            default:    begin r_data = 8'h00;    r_hit = 1'b0; end
        endcase
    end

endmodule
